// File: rtl/fir_mdc_job_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mdc_job_sched_if
// Brief    : Request/grant, job-issue and event bundle of the FIR job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_mdc_job_sched_if #(
   parameter int N_CORES   = 2,
   parameter int N_CONTEXT = 2,
   parameter int LEN_WIDTH = 32
);
   localparam int OWNER_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int CNT_W   = $clog2(N_CONTEXT + 1);

   logic [N_CORES-1:0]                req_i;
   logic [N_CORES-1:0][LEN_WIDTH-1:0] req_len_i;
   logic [N_CORES-1:0]                gnt_o;
   logic                              start_o;
   logic [LEN_WIDTH-1:0]              job_len_o;
   logic [OWNER_W-1:0]                job_owner_o;
   logic                              out_valid_i;
   logic                              out_ready_i;
   logic [N_CORES-1:0]                evt_o;
   logic                              busy_o;
   logic [CNT_W-1:0]                  fifo_cnt_o;
   logic                              err_o;

   modport master (
      output req_i, req_len_i, out_valid_i, out_ready_i,
      input  gnt_o, start_o, job_len_o, job_owner_o, evt_o, busy_o, fifo_cnt_o, err_o
   );

   modport slave (
      input  req_i, req_len_i, out_valid_i, out_ready_i,
      output gnt_o, start_o, job_len_o, job_owner_o, evt_o, busy_o, fifo_cnt_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/fir_mdc_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_mdc_job_sched
// Brief    : Round-robin job scheduler sharing one FIR datapath among cores.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mdc_job_sched #(
   parameter int N_CORES   = 2,
   parameter int N_CONTEXT = 2,
   parameter int LEN_WIDTH = 32
) (
   input  wire logic               clk_i,
   input  wire logic               rst_i,
   input  wire logic               clear_i,
   fir_mdc_job_sched_if.slave      bus
);
   localparam int OWNER_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int CNT_W   = $clog2(N_CONTEXT + 1);
   localparam int AW      = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
   localparam int ENTRY_W = OWNER_W + LEN_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ENTRY_W-1:0]   mem_q [N_CONTEXT];
   logic [ENTRY_W-1:0]   mem_d [N_CONTEXT];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0] job_len_q, job_len_d, smp_q, smp_d;
   logic [OWNER_W-1:0]   job_owner_q, job_owner_d;
   logic                 err_q, err_d;

   logic [N_CORES-1:0]   w_gnt;
   logic [OWNER_W-1:0]   w_gnt_idx;
   logic                 w_push, w_pop, w_hs;

   // Highest offset first so the nearest requester at/after the pointer wins.
   always_comb begin : arb
      int idx;
      idx       = 0;
      w_gnt     = '0;
      w_gnt_idx = '0;
      if (!rst_i && !clear_i && (cnt_q != CNT_W'(N_CONTEXT))) begin
         for (int o = N_CORES - 1; o >= 0; o--) begin
            idx = int'(rr_ptr_q) + o;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (bus.req_i[idx]) begin
               w_gnt      = '0;
               w_gnt[idx] = 1'b1;
               w_gnt_idx  = OWNER_W'(idx);
            end
         end
      end
   end

   assign w_push = |w_gnt;
   assign w_pop  = (state_q == ST_IDLE) && (cnt_q != '0);
   assign w_hs   = bus.out_valid_i & bus.out_ready_i;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      job_len_d   = job_len_q;
      job_owner_d = job_owner_q;
      smp_d       = smp_q;
      err_d       = err_q | (w_hs && (state_q != ST_RUN));
      cnt_d       = cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_push) begin
         mem_d[wr_ptr_q] = {w_gnt_idx, bus.req_len_i[w_gnt_idx]};
         wr_ptr_d = (wr_ptr_q == AW'(N_CONTEXT - 1)) ? '0 : wr_ptr_q + AW'(1);
         rr_ptr_d = (w_gnt_idx == OWNER_W'(N_CORES - 1)) ? '0 : w_gnt_idx + OWNER_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(N_CONTEXT - 1)) ? '0 : rd_ptr_q + AW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (w_pop) begin
               {job_owner_d, job_len_d} = mem_q[rd_ptr_q];
               state_d = ST_START;
            end
         end
         ST_START: begin
            smp_d   = '0;
            state_d = (job_len_q == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            // Terminal compare happens before the counter could ever wrap.
            if (w_hs) begin
               if ((smp_q + LEN_WIDTH'(1)) == job_len_q) state_d = ST_DONE;
               else smp_d = smp_q + LEN_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear_i) begin
         state_d     = ST_IDLE;
         rr_ptr_d    = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cnt_d       = '0;
         job_len_d   = '0;
         job_owner_d = '0;
         smp_d       = '0;
         err_d       = 1'b0;
         for (int i = 0; i < N_CONTEXT; i++) mem_d[i] = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         job_len_q   <= '0;
         job_owner_q <= '0;
         smp_q       <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < N_CONTEXT; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         job_len_q   <= job_len_d;
         job_owner_q <= job_owner_d;
         smp_q       <= smp_d;
         err_q       <= err_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.gnt_o       = w_gnt;
   assign bus.start_o     = (state_q == ST_START);
   assign bus.job_len_o   = job_len_q;
   assign bus.job_owner_o = job_owner_q;
   assign bus.evt_o       = (state_q == ST_DONE) ? (N_CORES'(1) << job_owner_q) : '0;
   assign bus.busy_o      = (state_q != ST_IDLE) || (cnt_q != '0);
   assign bus.fifo_cnt_o  = cnt_q;
   assign bus.err_o       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_fir_mdc_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mdc_job_sched
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mdc_job_sched;
   localparam int NC = 2;
   localparam int NX = 2;
   localparam int LW = 32;
   localparam int OW = 1;

   typedef struct packed {
      logic [OW-1:0] owner;
      logic [LW-1:0] len;
   } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic [NC-1:0]         req = '0;
   logic [NC-1:0][LW-1:0] req_len = '0;
   logic valid = 1'b0;
   logic ready = 1'b0;

   logic [NC-1:0] gnt, evt;
   logic          start, busy, err;
   logic [LW-1:0] job_len;
   logic [OW-1:0] owner;
   logic [1:0]    fcnt;

   int total = 0;
   int bad = 0;

   fir_mdc_job_sched_if #(.N_CORES(NC), .N_CONTEXT(NX), .LEN_WIDTH(LW)) bus ();

   fir_mdc_job_sched #(.N_CORES(NC), .N_CONTEXT(NX), .LEN_WIDTH(LW)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus)
   );

   assign bus.req_i       = req;
   assign bus.req_len_i   = req_len;
   assign bus.out_valid_i = valid;
   assign bus.out_ready_i = ready;
   assign gnt     = bus.gnt_o;
   assign evt     = bus.evt_o;
   assign start   = bus.start_o;
   assign busy    = bus.busy_o;
   assign err     = bus.err_o;
   assign job_len = bus.job_len_o;
   assign owner   = bus.job_owner_o;
   assign fcnt    = bus.fifo_cnt_o;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear = 1'b0;
      req = '0;
      valid = 1'b0;
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [NC-1:0] rr_pick(input logic [NC-1:0] r, input int p);
      logic [NC-1:0] g;
      int k;
      g = '0;
      for (int o = 0; o < NC; o++) begin
         k = (p + o) % NC;
         if (r[k] && (g == '0)) g[k] = 1'b1;
      end
      return g;
   endfunction

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if ({gnt, start, evt, busy, fcnt, err} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=0", {gnt, start, evt, busy, fcnt, err});
      end
      total++;
      if ({job_len, owner} !== '0) begin
         bad++;
         $display("FAIL reset_job got=%h want=0", {job_len, owner});
      end
   endtask

   task automatic test_single_job();
      do_reset();
      step(); req = 2'b01; req_len[0] = 32'd4;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b want=01", gnt); end
      step(); req = '0;
      @(negedge clk);
      total++;
      if ({start, fcnt} !== {1'b0, 2'd1}) begin bad++; $display("FAIL single_pop got=%b want=001", {start, fcnt}); end
      step();
      @(negedge clk);
      total++;
      if ({start, job_len, owner} !== {1'b1, 32'd4, 1'b0}) begin
         bad++;
         $display("FAIL single_start got=%b/%0d/%0d want=1/4/0", start, job_len, owner);
      end
      for (int i = 0; i < 4; i++) begin
         step(); valid = 1'b1; ready = 1'b1;
         @(negedge clk);
         total++;
         if ({evt, start} !== '0) begin bad++; $display("FAIL single_run%0d got=%b want=0", i, {evt, start}); end
      end
      step(); valid = 1'b0; ready = 1'b0;
      @(negedge clk);
      total++;
      if ({evt, busy} !== {2'b01, 1'b1}) begin bad++; $display("FAIL single_evt got=%b want=011", {evt, busy}); end
      step();
      @(negedge clk);
      total++;
      if ({evt, busy, err} !== '0) begin bad++; $display("FAIL single_idle got=%b want=0", {evt, busy, err}); end
   endtask

   task automatic test_rr();
      logic [NC-1:0] exp_g;
      logic [NC-1:0] gq[$];
      logic last_start;
      int ng, ne;
      exp_g = 2'b01;
      last_start = 1'b0;
      ng = 0;
      ne = 0;
      do_reset();
      req_len[0] = 32'd1;
      req_len[1] = 32'd1;
      for (int c = 0; c < 24; c++) begin
         step(); req = 2'b11; valid = last_start; ready = last_start;
         @(negedge clk);
         if (gnt != '0) begin
            total++;
            if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt%0d got=%b want=%b", ng, gnt, exp_g); end
            gq.push_back(gnt);
            exp_g = {exp_g[0], exp_g[1]};
            ng++;
         end
         if (evt != '0) begin
            total++;
            if (gq.size() == 0 || evt !== gq[0]) begin bad++; $display("FAIL rr_evt%0d got=%b want=%b", ne, evt, (gq.size() == 0) ? 2'b00 : gq[0]); end
            if (gq.size() != 0) void'(gq.pop_front());
            ne++;
         end
         last_start = start;
      end
      total++;
      if (ng < 3 || ne < 2 || err !== 1'b0) begin
         bad++;
         $display("FAIL rr_progress got=grants %0d evts %0d err %b want=>=3 >=2 0", ng, ne, err);
      end
   endtask

   task automatic test_fifo_full();
      do_reset();
      step(); req = 2'b01; req_len[0] = 32'd8;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL full_g0 got=%b want=01", gnt); end
      step(); req = 2'b10; req_len[1] = 32'd1;
      @(negedge clk);
      total++;
      if (gnt !== 2'b10) begin bad++; $display("FAIL full_g1 got=%b want=10", gnt); end
      step(); req = 2'b01; req_len[0] = 32'd2;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL full_g2 got=%b want=01", gnt); end
      step(); req = 2'b10; req_len[1] = 32'd3;
      for (int c = 0; c < 5; c++) begin
         if (c != 0) step();
         @(negedge clk);
         total++;
         if ({gnt, fcnt} !== {2'b00, 2'd2}) begin bad++; $display("FAIL full_hold%0d got=%b/%0d want=00/2", c, gnt, fcnt); end
      end
      for (int c = 0; c < 8; c++) begin
         step(); valid = 1'b1; ready = 1'b1;
         @(negedge clk);
         total++;
         if (gnt !== 2'b00) begin bad++; $display("FAIL full_run%0d got=%b want=00", c, gnt); end
      end
      step(); valid = 1'b0; ready = 1'b0;
      @(negedge clk);
      total++;
      if ({evt, gnt} !== {2'b01, 2'b00}) begin bad++; $display("FAIL full_evt got=%b want=0100", {evt, gnt}); end
      step();
      @(negedge clk);
      total++;
      if ({gnt, fcnt} !== {2'b00, 2'd2}) begin bad++; $display("FAIL full_pop got=%b/%0d want=00/2", gnt, fcnt); end
      step();
      @(negedge clk);
      total++;
      if ({gnt, fcnt} !== {2'b10, 2'd1}) begin bad++; $display("FAIL full_regrant got=%b/%0d want=10/1", gnt, fcnt); end
   endtask

   task automatic test_backpressure();
      logic [4:0] pat;
      pat = 5'b10101;
      do_reset();
      step(); req = 2'b01; req_len[0] = 32'd3;
      @(negedge clk);
      step(); req = '0;
      step();
      @(negedge clk);
      total++;
      if ({start, job_len} !== {1'b1, 32'd3}) begin bad++; $display("FAIL bp_start got=%b/%0d want=1/3", start, job_len); end
      for (int i = 0; i < 5; i++) begin
         step(); valid = 1'b1; ready = pat[i];
         @(negedge clk);
         total++;
         if (evt !== 2'b00) begin bad++; $display("FAIL bp_cycle%0d got=%b want=00", i, evt); end
      end
      step(); valid = 1'b0; ready = 1'b0;
      @(negedge clk);
      total++;
      if ({evt, err} !== {2'b01, 1'b0}) begin bad++; $display("FAIL bp_evt got=%b want=010", {evt, err}); end
   endtask

   task automatic test_zero_len();
      do_reset();
      step(); req = 2'b10; req_len[1] = 32'd0;
      @(negedge clk);
      total++;
      if (gnt !== 2'b10) begin bad++; $display("FAIL zero_gnt got=%b want=10", gnt); end
      step(); req = '0;
      step();
      @(negedge clk);
      total++;
      if ({start, job_len, owner} !== {1'b1, 32'd0, 1'b1}) begin
         bad++;
         $display("FAIL zero_start got=%b/%0d/%0d want=1/0/1", start, job_len, owner);
      end
      step();
      @(negedge clk);
      total++;
      if ({evt, start} !== {2'b10, 1'b0}) begin bad++; $display("FAIL zero_evt got=%b want=100", {evt, start}); end
      step();
      @(negedge clk);
      total++;
      if ({evt, busy, err} !== '0) begin bad++; $display("FAIL zero_idle got=%b want=0", {evt, busy, err}); end
   endtask

   task automatic test_reset_mid_job();
      int n_evt;
      n_evt = 0;
      do_reset();
      step(); req = 2'b01; req_len[0] = 32'd8;
      step(); req = 2'b10; req_len[1] = 32'd2;
      step(); req = '0;
      step(); valid = 1'b1; ready = 1'b1;
      step();
      step(); valid = 1'b0; ready = 1'b0; req = 2'b01;
      total++;
      if ({busy, fcnt} !== {1'b1, 2'd1}) begin bad++; $display("FAIL mid_before got=%b/%0d want=1/1", busy, fcnt); end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({gnt, start, evt, busy, fcnt, err, job_len, owner} !== '0) begin
         bad++;
         $display("FAIL mid_async got=%h want=0", {gnt, start, evt, busy, fcnt, err, job_len, owner});
      end
      step(); req = '0;
      step(); rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         @(negedge clk);
         if (evt != '0 || start) n_evt++;
      end
      total++;
      if (n_evt != 0 || fcnt !== 2'd0) begin bad++; $display("FAIL mid_noevt got=%0d/%0d want=0/0", n_evt, fcnt); end
      step(); valid = 1'b1; ready = 1'b1;
      step(); valid = 1'b0; ready = 1'b0;
      @(negedge clk);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err); end
      repeat (3) step();
      @(negedge clk);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
      step(); clear = 1'b1;
      step(); clear = 1'b0;
      @(negedge clk);
      total++;
      if ({err, busy, fcnt} !== '0) begin bad++; $display("FAIL err_clear got=%b want=0", {err, busy, fcnt}); end
   endtask

   task automatic test_random();
      job_t m_q[$];
      job_t m_job;
      int m_phase, m_ptr;
      int unsigned m_cnt;
      logic m_err, hs;
      logic [NC-1:0] eg, ee, gmask, one;
      m_phase = 0;
      m_ptr = 0;
      m_cnt = 0;
      m_err = 1'b0;
      m_job = '0;
      gmask = '0;
      one = 1;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         step();
         for (int i = 0; i < NC; i++) begin
            if (gmask[i]) req[i] = 1'b0;
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               req_len[i] = LW'($urandom_range(0, 5));
            end
         end
         gmask = '0;
         valid = (m_phase == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         ready = (m_phase == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         eg = (m_q.size() < NX) ? rr_pick(req, m_ptr) : '0;
         ee = (m_phase == 3) ? (one << m_job.owner) : '0;
         total++;
         if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c%0d got=%b want=%b", c, gnt, eg); end
         total++;
         if ({start, evt, busy, fcnt, err} !== {(m_phase == 1), ee, (m_phase != 0 || m_q.size() != 0), 2'(m_q.size()), m_err}) begin
            bad++;
            $display("FAIL rnd_status c%0d got=%b want=%b", c, {start, evt, busy, fcnt, err},
                     {(m_phase == 1), ee, (m_phase != 0 || m_q.size() != 0), 2'(m_q.size()), m_err});
         end
         if (m_phase != 0) begin
            total++;
            if ({owner, job_len} !== m_job) begin bad++; $display("FAIL rnd_job c%0d got=%h want=%h", c, {owner, job_len}, m_job); end
         end
         hs = valid & ready;
         if (hs && m_phase != 2) m_err = 1'b1;
         case (m_phase)
            0: if (m_q.size() != 0) begin m_job = m_q.pop_front(); m_phase = 1; end
            1: begin m_cnt = 0; m_phase = (m_job.len == 0) ? 3 : 2; end
            2: if (hs) begin m_cnt++; if (m_cnt == m_job.len) m_phase = 3; end
            default: m_phase = 0;
         endcase
         for (int k = 0; k < NC; k++) begin
            if (eg[k]) begin
               m_q.push_back(job_t'{owner: OW'(k), len: req_len[k]});
               m_ptr = (k + 1) % NC;
               gmask[k] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_rr();
      test_fifo_full();
      test_backpressure();
      test_zero_len();
      test_reset_mid_job();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
